mult_stream_adapter: RTL and testbench

Valid/ready front-end for the sequential shift-and-add (Booth) multiplier. Accepts signed operand pairs from an upstream stream, runs the multiplier's 4-phase START/end_mult handshake, captures the 2N-bit product, and presents it downstream with valid/ready. A one-entry operand buffer and a one-entry result register let the next pair be accepted while the multiplier runs. A watchdog flags a multiplier that never finishes.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_watchdog.sv | 28 ++
 rtl/mult_stream_adapter.sv | 132 +++++++++++++
 tb/tb_mult_stream_adapter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the Booth multiplier stream adapter.
// The state encoding and watchdog sizing live here so the top and watchdog agree.
package mult_pkg;

  localparam int DEF_N       = 8;
  localparam int DEF_TIMEOUT = 64;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int DEF_WD_W = wd_width(DEF_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_END = 2'd1,
    DROP     = 2'd2
  } state_t;

endpackage

// File: rtl/mult_watchdog.sv
// Saturating cycle counter with synchronous clear and enable; tc flags the
// enabled cycle on which the count reaches LIMIT (combinational, no stalls).
module mult_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mult_stream_adapter.sv
// Valid/ready wrapper around the START/end_mult multiplier: in->mul_start 2 cycles,
// mul_end->out_valid 1 cycle; a full result register stalls completion in WAIT_END.
module mult_stream_adapter
  import mult_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic           mul_end,
  input  logic [2*N-1:0] mul_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_product,
  output logic           busy,
  output logic           timeout_err
);

  localparam int WD_W = wd_width(TIMEOUT);

  state_t         state, state_nxt;
  logic           op_full;
  logic [N-1:0]   op_a, op_b;
  logic           res_full;
  logic           launch, capture, tmo_set;
  logic           wd_en, wd_tc;

  assign in_ready  = !op_full;
  assign out_valid = res_full;
  assign mul_start = (state == WAIT_END);
  assign busy      = (state != IDLE);
  // Only idle waiting counts; a held end_mult under backpressure never times out.
  assign wd_en     = mul_start && !mul_end;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (op_full) begin
          launch    = 1'b1;
          state_nxt = WAIT_END;
        end
      end
      WAIT_END: begin
        if (mul_end) begin
          if (!res_full || out_ready) begin
            capture   = 1'b1;
            state_nxt = DROP;
          end
        end else if (wd_tc) begin
          tmo_set   = 1'b1;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (!mul_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_full <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
    end else begin
      if (launch) op_full <= 1'b0;
      if (in_valid && in_ready) begin
        op_full <= 1'b1;
        op_a    <= in_a;
        op_b    <= in_b;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (launch) begin
      mul_a <= op_a;
      mul_b <= op_b;
    end
  end

  // Capture wins over the downstream pop so a simultaneous drain+refill stays full.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      res_full    <= 1'b0;
      out_product <= '0;
    end else if (capture) begin
      res_full    <= 1'b1;
      out_product <= mul_product;
    end else if (out_valid && out_ready) begin
      res_full    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       timeout_err <= 1'b0;
    else if (tmo_set) timeout_err <= 1'b1;
  end

  mult_watchdog #(
    .LIMIT (TIMEOUT),
    .W     (WD_W)
  ) u_watchdog (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (launch),
    .en    (wd_en),
    .tc    (wd_tc)
  );

endmodule

// File: tb/tb_mult_stream_adapter.sv
// Directed bench: 20-cycle multiplier model, product scoreboard and literal checks.
module tb_mult_stream_adapter;

  localparam int N   = 8;
  localparam int LAT = 20;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a, in_b;
  logic           mul_start;
  logic [N-1:0]   mul_a, mul_b;
  logic           mul_end;
  logic [2*N-1:0] mul_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  logic           stuck = 1'b0;
  logic           ov_seen = 1'b0;
  logic [2*N-1:0] expq[$];
  int             mcnt;

  mult_stream_adapter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_end     (mul_end),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier: end_mult LAT cycles after START rises, held until START drops.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mul_end     <= 1'b0;
      mcnt        <= 0;
      mul_product <= '0;
    end else if (!mul_start) begin
      mul_end <= 1'b0;
      mcnt    <= 0;
    end else if (!mul_end && !stuck) begin
      if (mcnt == LAT - 1) begin
        mul_end     <= 1'b1;
        mul_product <= 16'($signed(mul_a) * $signed(mul_b));
      end
      mcnt <= mcnt + 1;
    end
  end

  // Scoreboard: every accepted pair must come out as a*b, in order.
  initial begin
    logic       prev_start = 1'b0;
    logic       prev_terr  = 1'b0;
    logic [N-1:0] prev_a = '0, prev_b = '0;
    int pa, pb;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        expq.delete();
        prev_start = 1'b0;
        prev_terr  = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          pa = int'($signed(in_a));
          pb = int'($signed(in_b));
          expq.push_back(16'(pa * pb));
        end
        if (stuck && out_valid) ov_seen = 1'b1;
        if (timeout_err && !prev_terr && expq.size() > 0) void'(expq.pop_front());
        if (out_valid && out_ready) begin
          if (expq.size() == 0) check("unexpected_out", 32'(out_product), 32'hDEAD_BEEF);
          else check("sb_product", 32'(out_product), 32'(expq.pop_front()));
        end
        if (mul_start && prev_start) begin
          check("mul_a_stable", 32'(mul_a), 32'(prev_a));
          check("mul_b_stable", 32'(mul_b), 32'(prev_b));
        end
        prev_start = mul_start;
        prev_a     = mul_a;
        prev_b     = mul_b;
        prev_terr  = timeout_err;
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int k = 0;
    @(posedge CLK); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge CLK);
    while (!in_ready && k < 500) begin
      @(negedge CLK);
      k++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((busy || out_valid) && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    32'(in_ready),    32'd1);
    check({tag, "_out_valid"},   32'(out_valid),   32'd0);
    check({tag, "_mul_start"},   32'(mul_start),   32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_mul_a"},       32'(mul_a),       32'd0);
    check({tag, "_mul_b"},       32'(mul_b),       32'd0);
    check({tag, "_out_product"}, 32'(out_product), 32'd0);
  endtask

  initial begin
    int n, b, k;
    RESET = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge CLK);
    check_reset_outputs("rst0");
    @(posedge CLK); #1 RESET = 1'b1;

    // 3*5, measure launch latency and START length.
    send(8'd3, 8'd5);
    @(negedge CLK);
    check("lat_t1_start", 32'(mul_start), 32'd0);
    @(negedge CLK);
    check("lat_t2_start", 32'(mul_start), 32'd1);
    n = 1;
    @(negedge CLK);
    while (mul_start && n < 300) begin
      n++;
      @(negedge CLK);
    end
    check("start_len", 32'(n), 32'd21);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_product", 32'(out_product), 32'h000F);
    b = 0;
    while (busy && b < 50) begin
      @(negedge CLK);
      b++;
    end
    check("drop_len", 32'(b), 32'd2);

    // -7*6
    send(8'hF9, 8'd6);
    k = 0;
    while (!out_valid && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check("t2_product", 32'(out_product), 32'hFFD6);
    wait_idle("t2_idle");

    // Back-to-back with downstream stalled.
    @(posedge CLK); #1 out_ready = 1'b0;
    send(8'd3, 8'd5);
    send(8'hF9, 8'd6);
    check("b2b_first_running", 32'(mul_start), 32'd1);
    @(negedge CLK);
    check("b2b_in_ready_low", 32'(in_ready), 32'd0);
    k = 0;
    while (!(out_valid && mul_start && mul_end) && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check("b2b_hold_reached", 32'(out_valid && mul_start && mul_end), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("b2b_hold_start", 32'(mul_start && mul_end), 32'd1);
    end
    check("b2b_first_product", 32'(out_product), 32'd15);
    @(posedge CLK); #1 out_ready = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b0;
    @(negedge CLK);
    check("b2b_refill_valid", 32'(out_valid), 32'd1);
    check("b2b_second_product", 32'(out_product), 32'hFFD6);
    check("b2b_dropped_start", 32'(mul_start), 32'd0);
    @(posedge CLK); #1 out_ready = 1'b1;
    wait_idle("b2b_idle");
    check("b2b_drained", 32'(expq.size()), 32'd0);

    // Multiplier that never finishes.
    stuck = 1'b1;
    send(8'd1, 8'd2);
    k = 0;
    while (!mul_start && k < 10) begin
      @(negedge CLK);
      k++;
    end
    n = 0;
    while (mul_start && n < 300) begin
      n++;
      @(negedge CLK);
    end
    check("tmo_start_len", 32'(n), 32'd64);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    b = 0;
    while (busy && b < 50) begin
      @(negedge CLK);
      b++;
    end
    check("tmo_drop_len", 32'(b), 32'd1);
    repeat (5) @(negedge CLK);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    check("tmo_no_out", 32'(ov_seen), 32'd0);
    stuck = 1'b0;

    // Reset in the middle of a run.
    send(8'd5, 8'd5);
    repeat (6) @(negedge CLK);
    check("rst_mid_running", 32'(mul_start), 32'd1);
    @(posedge CLK); #1 RESET = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge CLK); @(posedge CLK); #1 RESET = 1'b1;
    send(8'd2, 8'd2);
    k = 0;
    while (!out_valid && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check("post_rst_product", 32'(out_product), 32'h0004);
    wait_idle("post_rst_idle");
    check("final_drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
